// File: rtl/rs_pkg.sv
// Shared definitions for the ALU reservation station: tag constants, opcodes,
// execution-unit states and the entry header type.
package rs_pkg;

    localparam int OPCODE_WIDTH = 4;

    // Tag value meaning "operand already holds a valid value" / "no destination".
    localparam int READY = 0;
    localparam int NULL  = 0;

    localparam logic [OPCODE_WIDTH-1:0] INST_ADD  = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] INST_ADDI = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUB  = 4'd3;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUBI = 4'd4;
    localparam logic [OPCODE_WIDTH-1:0] INST_MUL  = 4'd5;
    localparam logic [OPCODE_WIDTH-1:0] INST_MULI = 4'd6;

    typedef enum logic [1:0] {
        EXEC_IDLE,
        EXEC_MUL,
        EXEC_RESULT
    } exec_state_e;

    // Width-independent part of a station entry; operand fields live in the top.
    typedef struct packed {
        logic                    valid;
        logic [OPCODE_WIDTH-1:0] op;
    } rs_hdr_t;

    function automatic logic isMul(input logic [OPCODE_WIDTH-1:0] op);
        return (op == INST_MUL) || (op == INST_MULI);
    endfunction

endpackage

// File: rtl/alu_exec.sv
// Shared execution unit: accepts one dispatched op, runs add/sub in one cycle or
// mul over MUL_LAT cycles, and holds the result until the CDB arbiter takes it.
module alu_exec
    import rs_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    parameter int MUL_LAT   = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    dispatch_valid,
    output logic                    dispatch_ready,
    input  logic [OPCODE_WIDTH-1:0] dispatch_op,
    input  logic [WORD_SIZE-1:0]    dispatch_vj,
    input  logic [WORD_SIZE-1:0]    dispatch_vk,
    input  logic [RB_INDEX-1:0]     dispatch_dest,
    input  logic                    res_ready,
    output logic                    res_valid,
    output logic [WORD_SIZE-1:0]    res_data,
    output logic [RB_INDEX-1:0]     res_dest,
    output logic                    exec_busy
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [RB_INDEX-1:0] NULL_TAG = RB_INDEX'(NULL);

    exec_state_e            state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [WORD_SIZE-1:0]   mulA_q;
    logic [WORD_SIZE-1:0]   mulB_q;
    logic [RB_INDEX-1:0]    mulDest_q;
    logic                   resValid_q;
    logic [WORD_SIZE-1:0]   resData_q;
    logic [RB_INDEX-1:0]    resDest_q;
    logic                   take;

    function automatic logic [WORD_SIZE-1:0] aluResult(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [WORD_SIZE-1:0]    a,
        input logic [WORD_SIZE-1:0]    b
    );
        logic [WORD_SIZE-1:0] r;
        case (op)
            INST_ADD, INST_ADDI: r = a + b;
            INST_SUB, INST_SUBI: r = a - b;
            INST_MUL, INST_MULI: r = a * b;
            default:             r = '0;
        endcase
        return r;
    endfunction

    assign dispatch_ready = (state_q == EXEC_IDLE) || ((state_q == EXEC_RESULT) && res_ready);
    assign take           = dispatch_valid && dispatch_ready;

    // The counter is loaded with MUL_LAT-1 and the result lands on the edge where
    // it would reach zero, so a mul shows res_valid MUL_LAT-1 edges after dispatch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EXEC_IDLE;
            cnt_q      <= '0;
            mulA_q     <= '0;
            mulB_q     <= '0;
            mulDest_q  <= NULL_TAG;
            resValid_q <= 1'b0;
            resData_q  <= '0;
            resDest_q  <= NULL_TAG;
        end else if (flush) begin
            state_q    <= EXEC_IDLE;
            resValid_q <= 1'b0;
            resData_q  <= '0;
            resDest_q  <= NULL_TAG;
        end else if (take) begin
            if (isMul(dispatch_op) && (MUL_LAT > 1)) begin
                state_q    <= EXEC_MUL;
                cnt_q      <= CNT_W'(MUL_LAT - 1);
                mulA_q     <= dispatch_vj;
                mulB_q     <= dispatch_vk;
                mulDest_q  <= dispatch_dest;
                resValid_q <= 1'b0;
                resData_q  <= '0;
                resDest_q  <= NULL_TAG;
            end else begin
                state_q    <= EXEC_RESULT;
                resValid_q <= 1'b1;
                resData_q  <= aluResult(dispatch_op, dispatch_vj, dispatch_vk);
                resDest_q  <= dispatch_dest;
            end
        end else begin
            case (state_q)
                EXEC_MUL: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q    <= EXEC_RESULT;
                        resValid_q <= 1'b1;
                        resData_q  <= mulA_q * mulB_q;
                        resDest_q  <= mulDest_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                EXEC_RESULT: begin
                    if (res_ready) begin
                        state_q    <= EXEC_IDLE;
                        resValid_q <= 1'b0;
                        resData_q  <= '0;
                        resDest_q  <= NULL_TAG;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = resValid_q;
    assign res_data  = resData_q;
    assign res_dest  = resDest_q;
    assign exec_busy = (state_q != EXEC_IDLE);

endmodule

// File: rtl/alu_rs_multi.sv
// Multi-entry ALU reservation station: buffers issued ops, wakes operands from the
// ROB data bus and dispatches the oldest ready entry to the shared alu_exec unit.
module alu_rs_multi
    import rs_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    parameter int RB_SIZE   = 16,
    parameter int ENTRIES   = 4,
    parameter int MUL_LAT   = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [OPCODE_WIDTH-1:0]      issue_op,
    input  logic [WORD_SIZE-1:0]         issue_vj,
    input  logic [WORD_SIZE-1:0]         issue_vk,
    input  logic [RB_INDEX-1:0]          issue_qj,
    input  logic [RB_INDEX-1:0]          issue_qk,
    input  logic [RB_INDEX-1:0]          issue_dest,
    input  logic [RB_SIZE-1:0]           cdb_valid,
    input  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data,
    output logic                         res_valid,
    output logic [WORD_SIZE-1:0]         res_data,
    output logic [RB_INDEX-1:0]          res_dest,
    input  logic                         res_ready,
    output logic                         busy_out
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int AGE_W = $clog2(ENTRIES);
    localparam logic [AGE_W-1:0]    AGE_MAX   = AGE_W'(ENTRIES - 1);
    localparam logic [RB_INDEX-1:0] READY_TAG = RB_INDEX'(READY);

    typedef struct packed {
        rs_hdr_t              hdr;
        logic [WORD_SIZE-1:0] vj;
        logic [RB_INDEX-1:0]  qj;
        logic [WORD_SIZE-1:0] vk;
        logic [RB_INDEX-1:0]  qk;
        logic [RB_INDEX-1:0]  dest;
        logic [AGE_W-1:0]     age;
    } entry_t;

    entry_t             entries_q [ENTRIES];
    entry_t             entries_d [ENTRIES];
    entry_t             newEntry;
    logic               freeFound;
    logic [IDX_W-1:0]   freeIdx;
    logic               selFound;
    logic [IDX_W-1:0]   selIdx;
    logic [AGE_W-1:0]   selAge;
    logic               anyValid;
    logic               doAlloc;
    logic               dispatch;
    logic               execAccept;
    logic               execBusy;

    function automatic logic [WORD_SIZE-1:0] cdbWord(input logic [RB_INDEX-1:0] tag);
        return cdb_data[tag*WORD_SIZE +: WORD_SIZE];
    endfunction

    // Lowest free slot for allocation and oldest ready slot for dispatch; ties on
    // age (only possible after saturation) go to the lower index.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        selFound  = 1'b0;
        selIdx    = '0;
        selAge    = '0;
        anyValid  = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            anyValid = anyValid | entries_q[i].hdr.valid;
            if (!entries_q[i].hdr.valid && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
            if (entries_q[i].hdr.valid && (entries_q[i].qj == READY_TAG) &&
                (entries_q[i].qk == READY_TAG) &&
                (!selFound || (entries_q[i].age > selAge))) begin
                selFound = 1'b1;
                selIdx   = IDX_W'(i);
                selAge   = entries_q[i].age;
            end
        end
    end

    assign issue_ready = freeFound;
    assign doAlloc     = issue_valid && freeFound && !flush;
    assign dispatch    = selFound && execAccept && !flush;

    // Incoming entry, with same-cycle capture of operands already on the bus.
    always_comb begin
        newEntry           = '0;
        newEntry.hdr.valid = 1'b1;
        newEntry.hdr.op    = issue_op;
        newEntry.vj        = issue_vj;
        newEntry.qj        = issue_qj;
        newEntry.vk        = issue_vk;
        newEntry.qk        = issue_qk;
        newEntry.dest      = issue_dest;
        newEntry.age       = '0;
        if ((issue_qj != READY_TAG) && cdb_valid[issue_qj]) begin
            newEntry.vj = cdbWord(issue_qj);
            newEntry.qj = READY_TAG;
        end
        if ((issue_qk != READY_TAG) && cdb_valid[issue_qk]) begin
            newEntry.vk = cdbWord(issue_qk);
            newEntry.qk = READY_TAG;
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].hdr.valid) begin
                if ((entries_q[i].qj != READY_TAG) && cdb_valid[entries_q[i].qj]) begin
                    entries_d[i].vj = cdbWord(entries_q[i].qj);
                    entries_d[i].qj = READY_TAG;
                end
                if ((entries_q[i].qk != READY_TAG) && cdb_valid[entries_q[i].qk]) begin
                    entries_d[i].vk = cdbWord(entries_q[i].qk);
                    entries_d[i].qk = READY_TAG;
                end
                if (doAlloc && (entries_q[i].age != AGE_MAX)) begin
                    entries_d[i].age = entries_q[i].age + AGE_W'(1);
                end
            end
            if (dispatch && (selIdx == IDX_W'(i))) begin
                entries_d[i].hdr.valid = 1'b0;
            end
            if (doAlloc && (freeIdx == IDX_W'(i))) begin
                entries_d[i] = newEntry;
            end
            if (flush) begin
                entries_d[i].hdr.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    alu_exec #(
        .WORD_SIZE (WORD_SIZE),
        .RB_INDEX  (RB_INDEX),
        .MUL_LAT   (MUL_LAT)
    ) u_exec (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .dispatch_valid (dispatch),
        .dispatch_ready (execAccept),
        .dispatch_op    (entries_q[selIdx].hdr.op),
        .dispatch_vj    (entries_q[selIdx].vj),
        .dispatch_vk    (entries_q[selIdx].vk),
        .dispatch_dest  (entries_q[selIdx].dest),
        .res_ready      (res_ready),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_dest       (res_dest),
        .exec_busy      (execBusy)
    );

    assign busy_out = anyValid || execBusy;

endmodule

// File: tb/tb_alu_rs_multi.sv
// Scoreboard bench for alu_rs_multi: directed issues push expected results, a
// monitor pops and compares every accepted result offer.
module tb_alu_rs_multi;
    import rs_pkg::*;

    localparam int WS  = 32;
    localparam int RBI = 4;
    localparam int RBS = 16;
    localparam int ENT = 4;
    localparam int ML  = 3;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    flush;
    logic                    issue_valid;
    logic                    issue_ready;
    logic [OPCODE_WIDTH-1:0] issue_op;
    logic [WS-1:0]           issue_vj;
    logic [WS-1:0]           issue_vk;
    logic [RBI-1:0]          issue_qj;
    logic [RBI-1:0]          issue_qk;
    logic [RBI-1:0]          issue_dest;
    logic [RBS-1:0]          cdb_valid;
    logic [WS*RBS-1:0]       cdb_data;
    logic                    res_valid;
    logic [WS-1:0]           res_data;
    logic [RBI-1:0]          res_dest;
    logic                    res_ready;
    logic                    busy_out;

    typedef struct {
        logic [WS-1:0]  data;
        logic [RBI-1:0] dest;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    alu_rs_multi #(
        .WORD_SIZE (WS),
        .RB_INDEX  (RBI),
        .RB_SIZE   (RBS),
        .ENTRIES   (ENT),
        .MUL_LAT   (ML)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_vj    (issue_vj),
        .issue_vk    (issue_vk),
        .issue_qj    (issue_qj),
        .issue_qk    (issue_qk),
        .issue_dest  (issue_dest),
        .cdb_valid   (cdb_valid),
        .cdb_data    (cdb_data),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_dest    (res_dest),
        .res_ready   (res_ready),
        .busy_out    (busy_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [OPCODE_WIDTH-1:0] op, input logic [WS-1:0] vj,
                                 input logic [WS-1:0] vk, input logic [RBI-1:0] qj,
                                 input logic [RBI-1:0] qk, input logic [RBI-1:0] dest);
        issue_op    = op;
        issue_vj    = vj;
        issue_vk    = vk;
        issue_qj    = qj;
        issue_qk    = qk;
        issue_dest  = dest;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic pushExpect(input logic [WS-1:0] data, input logic [RBI-1:0] dest);
        exp_t e;
        e.data = data;
        e.dest = dest;
        expQ.push_back(e);
    endtask

    task automatic setCdb(input int tag, input logic [WS-1:0] data);
        cdb_valid[tag]          = 1'b1;
        cdb_data[tag*WS +: WS]  = data;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
    endtask

    // Compares every result the arbiter accepts against the oldest expectation.
    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && res_valid && res_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResult", 32'(res_dest), 32'hdead);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resData", res_data, e.data);
                    checkOutput("resDest", 32'(res_dest), 32'(e.dest));
                end
            end
        end
    endtask

    initial begin
        fork
            monitorLoop();
            begin
                reset_n     = 1'b0;
                flush       = 1'b0;
                issue_valid = 1'b0;
                issue_op    = '0;
                issue_vj    = '0;
                issue_vk    = '0;
                issue_qj    = '0;
                issue_qk    = '0;
                issue_dest  = '0;
                cdb_valid   = '0;
                cdb_data    = '0;
                res_ready   = 1'b1;
                tick();
                tick();
                checkOutput("rstResValid",   32'(res_valid),   32'd0);
                checkOutput("rstResData",    res_data,         32'd0);
                checkOutput("rstResDest",    32'(res_dest),    32'd0);
                checkOutput("rstIssueReady", 32'(issue_ready), 32'd1);
                checkOutput("rstBusy",       32'(busy_out),    32'd0);
                reset_n = 1'b1;
                tick();

                // Simple add with both operands ready
                pushExpect(32'd12, 4'd3);
                applyStimulus(INST_ADD, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3);
                tick();
                checkOutput("addLatency", 32'(res_valid), 32'd1);
                tick();
                tick();
                checkOutput("idleDest", 32'(res_dest), 32'd0);

                // Sub waiting on ROB slot 6
                pushExpect(32'd16, 4'd5);
                applyStimulus(INST_SUB, 32'd0, 32'd4, 4'd6, 4'd0, 4'd5);
                tick();
                setCdb(6, 32'd20);
                tick();
                cdb_valid = '0;
                checkOutput("subNotYet", 32'(res_valid), 32'd0);
                tick();
                checkOutput("subAfterWake", 32'(res_valid), 32'd1);
                waitDrain(10);

                // Fill the station, drop an extra issue, wake everything together
                for (int i = 1; i <= 4; i++) begin
                    pushExpect(32'(100 + i), RBI'(i));
                    applyStimulus(INST_ADD, 32'd0, 32'(i), 4'd8, 4'd0, RBI'(i));
                end
                checkOutput("fullNotReady", 32'(issue_ready), 32'd0);
                applyStimulus(INST_ADD, 32'd0, 32'd0, 4'd0, 4'd0, 4'd9);
                checkOutput("fullStillFull", 32'(issue_ready), 32'd0);
                setCdb(8, 32'd100);
                tick();
                cdb_valid = '0;
                waitDrain(20);
                tick();
                checkOutput("fullDrainedBusy", 32'(busy_out), 32'd0);

                // Multiply latency, with a following add queued behind it
                pushExpect(32'hFFFF_FFFE, 4'd6);
                pushExpect(32'd2, 4'd7);
                applyStimulus(INST_MULI, 32'hFFFF_FFFF, 32'd2, 4'd0, 4'd0, 4'd6);
                applyStimulus(INST_ADD, 32'd1, 32'd1, 4'd0, 4'd0, 4'd7);
                checkOutput("mulCycle1", 32'(res_valid), 32'd0);
                tick();
                checkOutput("mulCycle2", 32'(res_valid), 32'd0);
                tick();
                checkOutput("mulDone", 32'(res_valid), 32'd1);
                waitDrain(10);

                // Backpressure: result must hold, then back-to-back on release
                res_ready = 1'b0;
                pushExpect(32'd30, 4'd8);
                pushExpect(32'd7, 4'd9);
                applyStimulus(INST_ADD, 32'd10, 32'd20, 4'd0, 4'd0, 4'd8);
                applyStimulus(INST_ADD, 32'd3, 32'd4, 4'd0, 4'd0, 4'd9);
                for (int i = 0; i < 5; i++) begin
                    checkOutput("holdValid", 32'(res_valid), 32'd1);
                    checkOutput("holdData",  res_data,       32'd30);
                    checkOutput("holdDest",  32'(res_dest),  32'd8);
                    tick();
                end
                res_ready = 1'b1;
                tick();
                checkOutput("backToBack", 32'(res_valid), 32'd1);
                waitDrain(10);

                // Flush while a mul is in flight and another entry is waiting
                applyStimulus(INST_MUL, 32'd3, 32'd4, 4'd0, 4'd0, 4'd10);
                applyStimulus(INST_ADD, 32'd1, 32'd1, 4'd9, 4'd0, 4'd11);
                flush = 1'b1;
                tick();
                flush = 1'b0;
                checkOutput("flushResValid",   32'(res_valid),   32'd0);
                checkOutput("flushIssueReady", 32'(issue_ready), 32'd1);
                checkOutput("flushBusy",       32'(busy_out),    32'd0);
                checkOutput("flushResDest",    32'(res_dest),    32'd0);
                repeat (6) tick();

                // Reset while a result is being held
                res_ready = 1'b0;
                applyStimulus(INST_ADD, 32'd1, 32'd2, 4'd0, 4'd0, 4'd12);
                tick();
                checkOutput("preResetValid", 32'(res_valid), 32'd1);
                reset_n = 1'b0;
                tick();
                checkOutput("midRstResValid",   32'(res_valid),   32'd0);
                checkOutput("midRstIssueReady", 32'(issue_ready), 32'd1);
                checkOutput("midRstBusy",       32'(busy_out),    32'd0);
                checkOutput("midRstResDest",    32'(res_dest),    32'd0);
                reset_n   = 1'b1;
                res_ready = 1'b1;
                tick();

                pushExpect(32'd4, 4'd13);
                applyStimulus(INST_ADDI, 32'd2, 32'd2, 4'd0, 4'd0, 4'd13);
                waitDrain(10);
                repeat (3) tick();

                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $finish;
            end
        join_any
    end

endmodule
